// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state type and op legality check shared by alu_share_arb
package alu_pkg;
  localparam int W = 32;
  localparam int NREQ = 2;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way combinational round-robin picker
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = valid0 | valid1;
  assign grant_id = valid0 & valid1 ? ~last_grant : valid1;
endmodule

// File: rtl/yAlu.sv
// yAlu: 32-bit ALU (AND/OR/ADD/SUB/SLT) with zero flag ex
module yAlu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] z,
  output logic        ex
);
  logic [31:0] diff;
  assign diff = a - b;
  // SLT is the raw sign of a-b, no overflow correction
  assign z = op == 3'b000 ? a & b :
             op == 3'b001 ? a | b :
             op == 3'b010 ? a + b :
             op == 3'b110 ? diff :
             op == 3'b111 ? {31'b0, diff[31]} : 32'b0;
  assign ex = z == 32'b0;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one yAlu between two requesters with tagged response.
// Optional grant/conflict counters under ALU_ARB_STATS_EN.
module alu_share_arb
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_zero,
  output logic         resp_id,
  output logic         resp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1,
  output logic [15:0]  conflict_cnt
`endif
);
  state_t state, state_nx;
  logic last_grant, grant_valid, grant_id, accept, legal, alu_ex;
  logic [W-1:0] lat_a, lat_b, alu_z;
  logic [2:0] lat_op;
  rr_arb2 u_arb (
    .valid0(req0_valid),
    .valid1(req1_valid),
    .last_grant(last_grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id)
  );
  yAlu u_alu (
    .a(lat_a),
    .b(lat_b),
    .op(lat_op),
    .z(alu_z),
    .ex(alu_ex)
  );
  assign legal = is_legal_op(lat_op);
  always_comb begin
    accept = state == IDLE && grant_valid;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    resp_valid = state == RESP;
    state_nx = state == IDLE ? (grant_valid ? EXEC : IDLE) :
               state == EXEC ? RESP :
               resp_ready ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      lat_a <= '0;
      lat_b <= '0;
      lat_op <= OP_AND;
      resp_data <= '0;
      resp_zero <= 1'b0;
      resp_id <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_a <= grant_id ? req1_a : req0_a;
        lat_b <= grant_id ? req1_b : req0_b;
        lat_op <= grant_id ? req1_op : req0_op;
        resp_id <= grant_id;
      end
      if (state == EXEC) begin
        resp_data <= legal ? alu_z : '0;
        resp_zero <= legal ? alu_ex : 1'b1;
        resp_err <= !legal;
      end
      if (state == RESP && resp_ready) last_grant <= resp_id;
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      conflict_cnt <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (state == IDLE && req0_valid && req1_valid) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb
module tb_alu_share_arb;
  import alu_pkg::*;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, resp_ready = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, resp_valid, resp_zero, resp_id, resp_err;
  logic [31:0] resp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif
  int total = 0, bad = 0;
  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_id(resp_id), .resp_err(resp_err)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1; end
    else begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1; end
  endtask

  task automatic wait_ready(input int id, output bit ok);
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((id == 0 ? req0_ready : req1_ready) === 1'b1) begin ok = 1; break; end
    end
    step();
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic collect(output bit ok, output logic [31:0] d, output logic z, output logic rid, output logic e);
    ok = 0; d = '0; z = 0; rid = 0; e = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin ok = 1; d = resp_data; z = resp_zero; rid = resp_id; e = resp_err; break; end
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, resp_data, resp_zero, resp_id, resp_err, req0_ready, req1_ready} !== 38'b0) begin
      bad++; $display("FAIL reset_outputs got valid=%b data=%0h zero=%b id=%b err=%b r0=%b r1=%b want all 0",
        resp_valid, resp_data, resp_zero, resp_id, resp_err, req0_ready, req1_ready);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_tie();
    bit ok; logic [31:0] d; logic z, rid, e;
    resp_ready = 1;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin drive(0, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00); drive(1, OP_SUB, 9, 9); end
      else begin drive(0, OP_ADD, 1, 2); drive(1, OP_OR, 4, 8); end
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL tie%0d_grant got r0=%b r1=%b want r0=1 r1=0", r, req0_ready, req1_ready);
      end
      step();
      req0_valid = 0;
      collect(ok, d, z, rid, e);
      total++;
      if (!ok || d !== (r == 0 ? 32'hF000F000 : 32'd3) || rid !== 1'b0 || z !== 1'b0) begin
        bad++; $display("FAIL tie%0d_first got ok=%0d data=%0h id=%b zero=%b want data=%0h id=0 zero=0",
          r, ok, d, rid, z, (r == 0 ? 32'hF000F000 : 32'd3));
      end
      wait_ready(1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL tie%0d_req1_ready got timeout want ready", r); end
      collect(ok, d, z, rid, e);
      total++;
      if (!ok || d !== (r == 0 ? 32'd0 : 32'd12) || z !== (r == 0) || rid !== 1'b1) begin
        bad++; $display("FAIL tie%0d_second got ok=%0d data=%0h zero=%b id=%b want data=%0h zero=%b id=1",
          r, ok, d, z, rid, (r == 0 ? 32'd0 : 32'd12), r == 0);
      end
    end
  endtask

  task automatic test_single();
    drive(0, OP_ADD, 5, 7);
    resp_ready = 1;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL single_ready got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL single_exec got valid=%b r0=%b want 0 0", resp_valid, req0_ready);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'd12 || resp_zero !== 1'b0 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL single_resp got valid=%b data=%0d zero=%b id=%b err=%b want 1 12 0 0 0",
        resp_valid, resp_data, resp_zero, resp_id, resp_err);
    end
    step();
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_done got valid=%b want 0", resp_valid); end
    step();
  endtask

  task automatic test_backpressure();
    bit ok; logic [31:0] d; logic z, rid, e;
    resp_ready = 0;
    drive(1, OP_OR, 1, 2);
    wait_ready(1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_accept got timeout want ready"); end
    drive(0, OP_ADD, 100, 200);
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL bp_exec got valid=%b r0=%b want 0 0", resp_valid, req0_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_data !== 32'd3 || resp_id !== 1'b1 || req0_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got valid=%b data=%0h id=%b r0=%b want 1 3 1 0",
          i, resp_valid, resp_data, resp_id, req0_ready);
      end
    end
    step();
    resp_ready = 1;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'd3) begin
      bad++; $display("FAIL bp_release got valid=%b data=%0h want 1 3", resp_valid, resp_data);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req0_ready !== 1'b1) begin
      bad++; $display("FAIL bp_complete got valid=%b r0=%b want 0 1", resp_valid, req0_ready);
    end
    step();
    req0_valid = 0;
    collect(ok, d, z, rid, e);
    total++;
    if (!ok || d !== 32'd300 || rid !== 1'b0) begin
      bad++; $display("FAIL bp_next got ok=%0d data=%0d id=%b want 300 0", ok, d, rid);
    end
  endtask

  task automatic test_illegal();
    bit ok; logic [31:0] d; logic z, rid, e;
    resp_ready = 1;
    drive(0, 3'b100, 5, 5);
    wait_ready(0, ok);
    collect(ok, d, z, rid, e);
    total++;
    if (!ok || e !== 1'b1 || d !== 32'd0 || z !== 1'b1) begin
      bad++; $display("FAIL illegal got ok=%0d err=%b data=%0h zero=%b want 1 0 1", ok, e, d, z);
    end
    drive(0, OP_SLT, 3, 8);
    wait_ready(0, ok);
    collect(ok, d, z, rid, e);
    total++;
    if (!ok || e !== 1'b0 || d !== 32'd1 || z !== 1'b0) begin
      bad++; $display("FAIL slt_after got ok=%0d err=%b data=%0h zero=%b want 0 1 0", ok, e, d, z);
    end
  endtask

  task automatic test_reset_midop();
    bit ok; logic [31:0] d; logic z, rid, e;
    resp_ready = 1;
    drive(1, OP_ADD, 7, 7);
    wait_ready(1, ok);
    #1;
    rst_n = 0;
    #1;
    total++;
    if ({resp_valid, resp_data, resp_zero, resp_id, resp_err} !== 36'b0) begin
      bad++; $display("FAIL midop_reset got valid=%b data=%0h zero=%b id=%b err=%b want all 0",
        resp_valid, resp_data, resp_zero, resp_id, resp_err);
    end
    step();
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL midop_stale%0d got valid=%b want 0", i, resp_valid); end
    end
    step();
    drive(0, OP_ADD, 1, 1);
    wait_ready(0, ok);
    collect(ok, d, z, rid, e);
    total++;
    if (!ok || d !== 32'd2 || rid !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL midop_after got ok=%0d data=%0d id=%b err=%b want 2 0 0", ok, d, rid, e);
    end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    bit ok; logic [31:0] d; logic z, rid, e;
    resp_ready = 1;
    rst_n = 0;
    #1;
    step();
    rst_n = 1;
    total++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0 || conflict_cnt !== 16'd0) begin
      bad++; $display("FAIL stats_reset got %0d %0d %0d want 0 0 0", grant_cnt0, grant_cnt1, conflict_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, OP_ADD, i, 1);
      wait_ready(0, ok);
      collect(ok, d, z, rid, e);
    end
    for (int r = 0; r < 2; r++) begin
      drive(0, OP_OR, 1, 0);
      drive(1, OP_OR, 2, 0);
      @(negedge clk);
      total++;
      if (req1_ready !== 1'b1) begin bad++; $display("FAIL stats_tie%0d got r1=%b want 1", r, req1_ready); end
      step();
      req1_valid = 0;
      collect(ok, d, z, rid, e);
      wait_ready(0, ok);
      collect(ok, d, z, rid, e);
    end
    total++;
    if (grant_cnt0 !== 16'd5 || grant_cnt1 !== 16'd2 || conflict_cnt !== 16'd2) begin
      bad++; $display("FAIL stats_counts got %0d %0d %0d want 5 2 2", grant_cnt0, grant_cnt1, conflict_cnt);
    end
    force dut.grant_cnt0 = 16'hFFFF;
    #1;
    release dut.grant_cnt0;
    drive(0, OP_ADD, 0, 0);
    wait_ready(0, ok);
    collect(ok, d, z, rid, e);
    total++;
    if (grant_cnt0 !== 16'd0) begin bad++; $display("FAIL stats_wrap got %0h want 0", grant_cnt0); end
  endtask
`endif

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_illegal();
    test_reset_midop();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
